// File: rtl/inbound_pkg.sv
// Shared constants, command-word layout and state types for the inbound command dispatcher.
package inbound_pkg;

  localparam logic [1:0]  US_CMD_WR32_TYPE = 2'b01;

  localparam logic [10:0] REG_CMD         = 11'h000;
  localparam logic [10:0] REG_LEN         = 11'h004;
  localparam logic [10:0] REG_STATUS      = 11'h008;
  localparam logic [10:0] REG_ERR         = 11'h00C;
  localparam logic [10:0] REG_ADDR_BASE   = 11'h010;
  localparam int          REG_ADDR_STRIDE = 8;

  localparam int CMD_TYPE_LSB = 62;
  localparam int CMD_LEN_LSB  = 57;
  localparam int CMD_ID_LSB   = 54;
  localparam int CMD_ADDR_LSB = 0;

  typedef enum logic [1:0] {
    CH_IDLE        = 2'd0,
    CH_PENDING     = 2'd1,
    CH_OUTSTANDING = 2'd2
  } ch_state_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } disp_state_e;

  function automatic logic [10:0] addr_reg_off(input int ch);
    return REG_ADDR_BASE + 11'(ch * REG_ADDR_STRIDE);
  endfunction

  function automatic logic [127:0] build_cmd(input logic [4:0] len, input logic [2:0] id,
                                             input logic [31:0] addr);
    logic [127:0] w;
    w = 128'h0;
    w[CMD_TYPE_LSB +: 2] = US_CMD_WR32_TYPE;
    w[CMD_LEN_LSB +: 5]  = len;
    w[CMD_ID_LSB +: 3]   = id;
    w[CMD_ADDR_LSB +: 32] = addr;
    return w;
  endfunction

endpackage

// File: rtl/inbound_cmd_dispatch_rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int  N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  // ptr_r is the first index searched, i.e. one past the last winner
  logic [IW-1:0] ptr_r;
  logic [IW:0]   raw_s;
  logic [IW:0]   idx_s;
  logic          found_s;
  logic          hit_s;

  // scan requests starting at the pointer
  always_comb begin
    grant     = {N{1'b0}};
    grant_idx = {IW{1'b0}};
    found_s   = 1'b0;
    raw_s     = {(IW+1){1'b0}};
    idx_s     = {(IW+1){1'b0}};
    hit_s     = 1'b0;
    for (int k = 0; k < N; k++) begin
      raw_s            = {1'b0, ptr_r} + (IW+1)'(k);
      idx_s            = (raw_s >= (IW+1)'(N)) ? (raw_s - (IW+1)'(N)) : raw_s;
      hit_s            = !found_s && req[idx_s[IW-1:0]];
      grant[idx_s[IW-1:0]] = grant[idx_s[IW-1:0]] | hit_s;
      grant_idx        = hit_s ? idx_s[IW-1:0] : grant_idx;
      found_s          = found_s | hit_s;
    end
  end

  // advance the pointer past the winner when the grant is consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= {IW{1'b0}};
    end else if (advance) begin
      if (grant_idx == IW'(N - 1)) begin
        ptr_r <= {IW{1'b0}};
      end else begin
        ptr_r <= grant_idx + IW'(1);
      end
    end
  end

endmodule

// File: rtl/inbound_cmd_dispatch.sv
// BAR-side dispatcher: host-programmed channels are round-robined into the upstream command FIFO
// and tracked until the upstream engine reports completion.
module inbound_cmd_dispatch
  import inbound_pkg::*;
#(
  parameter int  NUM_CH   = 4,
  localparam int CMD_ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en_i,
  input  logic [10:0]         wr_addr_i,
  input  logic [7:0]          wr_be_i,
  input  logic [31:0]         wr_data_i,
  output logic                wr_busy_o,
  input  logic [10:0]         rd_addr_i,
  output logic [31:0]         rd_data_o,
  input  logic                up_wr_cmd_compl_i,
  input  logic [CMD_ID_W-1:0] cmd_id_i,
  input  logic                us_cmd_fifo_full_i,
  input  logic                us_cmd_fifo_prog_full_i,
  output logic [127:0]        us_cmd_fifo_din_o,
  output logic                us_cmd_fifo_wr_en_o,
  output logic                irq_o
);

  ch_state_e           ch_state_r [NUM_CH];
  ch_state_e           ch_state_s [NUM_CH];
  disp_state_e         state_r, state_s;
  logic [29:0]         addr_r [NUM_CH];
  logic [4:0]          len_r;
  logic [NUM_CH-1:0]   status_r, status_s, status_clr_s;
  logic [2:0]          err_r, err_s, err_clr_s;
  logic [NUM_CH-1:0]   wait_mask_r, wait_mask_s;
  logic [NUM_CH-1:0]   pending_s, outstanding_s, launch_req_s, launch_ok_s;
  logic [NUM_CH-1:0]   compl_hit_s, push_mask_s, grant_s, issue_oh_r;
  logic [CMD_ID_W-1:0] grant_idx_s;
  logic                launch_err_s, compl_miss_s, wr_acc_s, wr_drop_s;
  logic                sel_cmd_s, sel_len_s, sel_status_s, sel_err_s;
  logic                go_s, push_s, busy_r, irq_r;
  logic [31:0]         rd_data_r, rd_data_s;
  logic [127:0]        din_r;
  logic                be_hi_unused_s;

  assign be_hi_unused_s = ^wr_be_i[7:4];
  assign wr_acc_s     = wr_en_i && !busy_r && (wr_be_i[3:0] == 4'hF);
  assign wr_drop_s    = wr_en_i && busy_r;
  assign sel_cmd_s    = wr_acc_s && (wr_addr_i == REG_CMD);
  assign sel_len_s    = wr_acc_s && (wr_addr_i == REG_LEN);
  assign sel_status_s = wr_acc_s && (wr_addr_i == REG_STATUS);
  assign sel_err_s    = wr_acc_s && (wr_addr_i == REG_ERR);

  // full gates the push itself so a late full never sees a write strobe
  assign go_s   = (state_r == S_IDLE) && (|pending_s) && !us_cmd_fifo_full_i && !us_cmd_fifo_prog_full_i;
  assign push_s = (state_r == S_ISSUE) && !us_cmd_fifo_full_i;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (pending_s),
    .advance   (go_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  // per-channel next state; completion is applied before a same-cycle launch
  always_comb begin
    launch_err_s = 1'b0;
    pending_s     = {NUM_CH{1'b0}};
    outstanding_s = {NUM_CH{1'b0}};
    launch_req_s  = {NUM_CH{1'b0}};
    launch_ok_s   = {NUM_CH{1'b0}};
    compl_hit_s   = {NUM_CH{1'b0}};
    push_mask_s   = push_s ? issue_oh_r : {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      pending_s[i]     = (ch_state_r[i] == CH_PENDING);
      outstanding_s[i] = (ch_state_r[i] == CH_OUTSTANDING);
      compl_hit_s[i]   = up_wr_cmd_compl_i && (cmd_id_i == CMD_ID_W'(i)) && outstanding_s[i];
      launch_req_s[i]  = sel_cmd_s && wr_data_i[i];
      launch_ok_s[i]   = launch_req_s[i] && ((ch_state_r[i] == CH_IDLE) || compl_hit_s[i]);
      launch_err_s     = launch_err_s | (launch_req_s[i] & !launch_ok_s[i]);
      if (launch_ok_s[i]) begin
        ch_state_s[i] = CH_PENDING;
      end else if (push_mask_s[i]) begin
        ch_state_s[i] = CH_OUTSTANDING;
      end else if (compl_hit_s[i]) begin
        ch_state_s[i] = CH_IDLE;
      end else begin
        ch_state_s[i] = ch_state_r[i];
      end
    end
  end

  assign compl_miss_s = up_wr_cmd_compl_i && (compl_hit_s == {NUM_CH{1'b0}});
  assign status_clr_s = sel_status_s ? wr_data_i[NUM_CH-1:0] : {NUM_CH{1'b0}};
  assign err_clr_s    = sel_err_s ? wr_data_i[2:0] : 3'b000;
  // set terms are OR-ed after the clear so a same-cycle event survives W1C
  assign status_s     = (status_r & ~status_clr_s) | compl_hit_s;
  assign err_s        = (err_r & ~err_clr_s) | {compl_miss_s, wr_drop_s, launch_err_s};
  assign wait_mask_s  = (wait_mask_r & ~push_mask_s) | launch_ok_s;

  // dispatcher next state
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (go_s) state_s = S_ISSUE;
        else      state_s = S_IDLE;
      end
      S_ISSUE: begin
        if (push_s) state_s = S_IDLE;
        else        state_s = S_ISSUE;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // registered read mux
  always_comb begin
    rd_data_s = 32'h0;
    case (rd_addr_i)
      REG_CMD:    rd_data_s[NUM_CH-1:0] = pending_s | outstanding_s;
      REG_LEN:    rd_data_s[4:0]        = len_r;
      REG_STATUS: rd_data_s[NUM_CH-1:0] = status_r;
      REG_ERR:    rd_data_s[2:0]        = err_r;
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          rd_data_s = rd_data_s | ((rd_addr_i == addr_reg_off(i)) ? {addr_r[i], 2'b00} : 32'h0);
        end
      end
    endcase
  end

  // register file, channel state and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_state_r[i] <= CH_IDLE;
        addr_r[i]     <= 30'h0;
      end
      len_r       <= 5'h0;
      status_r    <= {NUM_CH{1'b0}};
      err_r       <= 3'b000;
      wait_mask_r <= {NUM_CH{1'b0}};
      busy_r      <= 1'b0;
      irq_r       <= 1'b0;
      rd_data_r   <= 32'h0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_state_r[i] <= ch_state_s[i];
        if (wr_acc_s && (wr_addr_i == addr_reg_off(i))) addr_r[i] <= wr_data_i[31:2];
      end
      if (sel_len_s) len_r <= wr_data_i[4:0];
      status_r    <= status_s;
      err_r       <= err_s;
      wait_mask_r <= wait_mask_s;
      busy_r      <= wr_acc_s || (|wait_mask_s);
      irq_r       <= |status_s;
      rd_data_r   <= rd_data_s;
    end
  end

  // dispatcher state and command word captured at the arbitration decision
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      issue_oh_r <= {NUM_CH{1'b0}};
      din_r      <= 128'h0;
    end else begin
      state_r <= state_s;
      if (go_s) begin
        issue_oh_r <= grant_s;
        din_r      <= build_cmd(len_r, 3'(grant_idx_s), {addr_r[grant_idx_s], 2'b00});
      end
    end
  end

  assign wr_busy_o           = busy_r;
  assign rd_data_o           = rd_data_r;
  assign irq_o               = irq_r;
  assign us_cmd_fifo_din_o   = din_r;
  assign us_cmd_fifo_wr_en_o = push_s;

endmodule

// File: tb/tb_inbound_cmd_dispatch.sv
// Directed self-checking bench for inbound_cmd_dispatch with NUM_CH = 4.
module tb_inbound_cmd_dispatch;

  localparam logic [1:0] EXP_TYPE = 2'b01;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic [10:0]  wr_addr = 11'h0;
  logic [7:0]   wr_be = 8'hFF;
  logic [31:0]  wr_data = 32'h0;
  logic         wr_busy;
  logic [10:0]  rd_addr = 11'h0;
  logic [31:0]  rd_data;
  logic         compl = 1'b0;
  logic [1:0]   cmd_id = 2'd0;
  logic         fifo_full = 1'b0;
  logic         fifo_pfull = 1'b0;
  logic [127:0] din;
  logic         push;
  logic         irq;

  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;
  int last_strobe = 0;
  int full_viol = 0;
  logic [127:0] push_q[$];
  int           push_cyc_q[$];

  inbound_cmd_dispatch #(.NUM_CH(4)) dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be),
    .wr_data_i(wr_data), .wr_busy_o(wr_busy), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .up_wr_cmd_compl_i(compl), .cmd_id_i(cmd_id), .us_cmd_fifo_full_i(fifo_full),
    .us_cmd_fifo_prog_full_i(fifo_pfull), .us_cmd_fifo_din_o(din),
    .us_cmd_fifo_wr_en_o(push), .irq_o(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (push) begin
      push_q.push_back(din);
      push_cyc_q.push_back(cyc);
      if (fifo_full) full_viol++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [10:0] a, input logic [31:0] d);
    tick();
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = 8'hFF;
    last_strobe = cyc;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [10:0] a, output logic [31:0] d);
    tick();
    rd_addr = a;
    tick();
    d = rd_data;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    while (wr_busy && n < bound) begin
      tick();
      n++;
    end
    ncmp++;
    if (wr_busy !== 1'b0) begin nerr++; $display("FAIL %s busy timeout got %b exp 0", name, wr_busy); end
  endtask

  task automatic pulse_compl(input logic [1:0] id);
    tick();
    compl = 1'b1; cmd_id = id;
    tick();
    compl = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1; wr_en = 1'b0; compl = 1'b0; fifo_full = 1'b0; fifo_pfull = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    push_q.delete();
    push_cyc_q.delete();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    ncmp++; if (wr_busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b exp 0", wr_busy); end
    ncmp++; if (rd_data !== 32'h0) begin nerr++; $display("FAIL rst_rd_data got %h exp 0", rd_data); end
    ncmp++; if (push !== 1'b0) begin nerr++; $display("FAIL rst_push got %b exp 0", push); end
    ncmp++; if (din !== 128'h0) begin nerr++; $display("FAIL rst_din got %h exp 0", din); end
    ncmp++; if (irq !== 1'b0) begin nerr++; $display("FAIL rst_irq got %b exp 0", irq); end
    rst = 1'b0;
  endtask

  task automatic test_regs();
    logic [31:0] d;
    do_reset();
    wr(11'h020, 32'h1234_5678);
    ncmp++; if (wr_busy !== 1'b1) begin nerr++; $display("FAIL addr_busy_pulse got %b exp 1", wr_busy); end
    tick();
    ncmp++; if (wr_busy !== 1'b0) begin nerr++; $display("FAIL addr_busy_end got %b exp 0", wr_busy); end
    rd(11'h020, d);
    ncmp++; if (d !== 32'h1234_5678) begin nerr++; $display("FAIL addr2_rt got %h exp 12345678", d); end
    wr(11'h018, 32'hABCD_EF03); wait_idle(4, "addr1_wr");
    rd(11'h018, d);
    ncmp++; if (d !== 32'hABCD_EF00) begin nerr++; $display("FAIL addr1_lowbits got %h exp abcdef00", d); end
    wr(11'h038, 32'hFFFF_FFFF); wait_idle(4, "addr5_wr");
    rd(11'h038, d);
    ncmp++; if (d !== 32'h0) begin nerr++; $display("FAIL addr5_unmapped got %h exp 0", d); end
    wr(11'h004, 32'hFFFF_FFFF); wait_idle(4, "len_wr");
    rd(11'h004, d);
    ncmp++; if (d !== 32'h1F) begin nerr++; $display("FAIL len_rt got %h exp 1f", d); end
    tick();
    wr_en = 1'b1; wr_addr = 11'h004; wr_data = 32'h3; wr_be = 8'h07;
    tick();
    wr_en = 1'b0; wr_be = 8'hFF;
    ncmp++; if (wr_busy !== 1'b0) begin nerr++; $display("FAIL partial_be_busy got %b exp 0", wr_busy); end
    rd(11'h004, d);
    ncmp++; if (d !== 32'h1F) begin nerr++; $display("FAIL partial_be_ignored got %h exp 1f", d); end
  endtask

  task automatic test_launch_rr();
    logic [31:0] addrs [4];
    logic [127:0] exp;
    logic [31:0] d;
    int s;
    addrs[0] = 32'h8000_1000; addrs[1] = 32'h1357_9BD0;
    addrs[2] = 32'hCAFE_0040; addrs[3] = 32'h0F0F_F0F0;
    do_reset();
    wr(11'h004, 32'd7); wait_idle(4, "rr_len");
    for (int i = 0; i < 4; i++) begin
      wr(11'h010 + 11'(8 * i), addrs[i]); wait_idle(4, "rr_addr");
    end
    push_q.delete(); push_cyc_q.delete();
    wr(11'h000, 32'hF);
    s = last_strobe;
    wait_idle(40, "rr_drain");
    ncmp++; if (push_q.size() !== 4) begin nerr++; $display("FAIL rr_count got %0d exp 4", push_q.size()); end
    for (int k = 0; k < 4 && k < push_q.size(); k++) begin
      exp = 128'h0;
      exp[63:62] = EXP_TYPE; exp[61:57] = 5'd7; exp[56:54] = 3'(k); exp[31:0] = addrs[k];
      ncmp++; if (push_q[k] !== exp) begin nerr++; $display("FAIL rr_word%0d got %h exp %h", k, push_q[k], exp); end
      ncmp++; if (push_cyc_q[k] !== s + 2 + 2 * k) begin
        nerr++; $display("FAIL rr_cycle%0d got %0d exp %0d", k, push_cyc_q[k] - s, 2 + 2 * k);
      end
    end
    rd(11'h000, d);
    ncmp++; if (d !== 32'hF) begin nerr++; $display("FAIL rr_cmd_rd got %h exp f", d); end
  endtask

  task automatic test_backpressure();
    do_reset();
    fifo_pfull = 1'b1;
    wr(11'h000, 32'h3);
    repeat (8) tick();
    ncmp++; if (push_q.size() !== 0) begin nerr++; $display("FAIL bp_pfull_push got %0d exp 0", push_q.size()); end
    ncmp++; if (wr_busy !== 1'b1) begin nerr++; $display("FAIL bp_busy_held got %b exp 1", wr_busy); end
    fifo_pfull = 1'b0; fifo_full = 1'b1;
    repeat (5) tick();
    ncmp++; if (push_q.size() !== 0) begin nerr++; $display("FAIL bp_full_push got %0d exp 0", push_q.size()); end
    fifo_full = 1'b0;
    wait_idle(20, "bp_drain");
    ncmp++; if (push_q.size() !== 2) begin nerr++; $display("FAIL bp_count got %0d exp 2", push_q.size()); end
    if (push_q.size() == 2) begin
      ncmp++; if (push_q[0][56:54] !== 3'd0) begin nerr++; $display("FAIL bp_id0 got %0d exp 0", push_q[0][56:54]); end
      ncmp++; if (push_q[1][56:54] !== 3'd1) begin nerr++; $display("FAIL bp_id1 got %0d exp 1", push_q[1][56:54]); end
      ncmp++; if (cyc !== push_cyc_q[1] + 1) begin
        nerr++; $display("FAIL bp_busy_clear got %0d exp %0d", cyc, push_cyc_q[1] + 1);
      end
    end
    ncmp++; if (full_viol !== 0) begin nerr++; $display("FAIL push_while_full got %0d exp 0", full_viol); end
  endtask

  task automatic test_completion();
    logic [31:0] d;
    do_reset();
    wr(11'h000, 32'h3); wait_idle(20, "cpl_issue");
    ncmp++; if (push_q.size() !== 2) begin nerr++; $display("FAIL cpl_issue_count got %0d exp 2", push_q.size()); end
    pulse_compl(2'd1);
    ncmp++; if (irq !== 1'b1) begin nerr++; $display("FAIL cpl_irq got %b exp 1", irq); end
    rd(11'h008, d);
    ncmp++; if (d !== 32'h2) begin nerr++; $display("FAIL cpl_status got %h exp 2", d); end
    rd(11'h000, d);
    ncmp++; if (d !== 32'h1) begin nerr++; $display("FAIL cpl_cmd_rd got %h exp 1", d); end
    wr(11'h008, 32'h2);
    ncmp++; if (irq !== 1'b0) begin nerr++; $display("FAIL cpl_irq_clear got %b exp 0", irq); end
    rd(11'h008, d);
    ncmp++; if (d !== 32'h0) begin nerr++; $display("FAIL cpl_status_clear got %h exp 0", d); end
    tick();
    wr_en = 1'b1; wr_addr = 11'h008; wr_data = 32'h1; compl = 1'b1; cmd_id = 2'd0;
    tick();
    wr_en = 1'b0; compl = 1'b0;
    rd(11'h008, d);
    ncmp++; if (d !== 32'h1) begin nerr++; $display("FAIL w1c_vs_cpl got %h exp 1", d); end
    ncmp++; if (irq !== 1'b1) begin nerr++; $display("FAIL w1c_vs_cpl_irq got %b exp 1", irq); end
  endtask

  task automatic test_errors();
    logic [31:0] d;
    do_reset();
    wr(11'h000, 32'h1); wait_idle(20, "err_issue");
    push_q.delete(); push_cyc_q.delete();
    wr(11'h000, 32'h1); wait_idle(4, "err_relaunch");
    repeat (4) tick();
    ncmp++; if (push_q.size() !== 0) begin nerr++; $display("FAIL err_relaunch_push got %0d exp 0", push_q.size()); end
    rd(11'h00C, d);
    ncmp++; if (d !== 32'h1) begin nerr++; $display("FAIL err_relaunch got %h exp 1", d); end
    wr(11'h00C, 32'h7); wait_idle(4, "err_clr1");
    pulse_compl(2'd3);
    rd(11'h00C, d);
    ncmp++; if (d !== 32'h4) begin nerr++; $display("FAIL err_bad_cpl got %h exp 4", d); end
    wr(11'h00C, 32'h7); wait_idle(4, "err_clr2");
    tick();
    wr_en = 1'b1; wr_addr = 11'h018; wr_data = 32'hDEAD_BEE0;
    tick();
    wr_data = 32'h1111_1110;
    tick();
    wr_en = 1'b0;
    wait_idle(4, "err_drop");
    rd(11'h018, d);
    ncmp++; if (d !== 32'hDEAD_BEE0) begin nerr++; $display("FAIL err_drop_data got %h exp deadbee0", d); end
    rd(11'h00C, d);
    ncmp++; if (d !== 32'h2) begin nerr++; $display("FAIL err_drop_flag got %h exp 2", d); end
    wr(11'h00C, 32'h7); wait_idle(4, "err_clr3");
    push_q.delete(); push_cyc_q.delete();
    tick();
    wr_en = 1'b1; wr_addr = 11'h000; wr_data = 32'h1; compl = 1'b1; cmd_id = 2'd0;
    tick();
    wr_en = 1'b0; compl = 1'b0;
    wait_idle(20, "cpl_launch");
    rd(11'h00C, d);
    ncmp++; if (d !== 32'h0) begin nerr++; $display("FAIL cpl_launch_err got %h exp 0", d); end
    ncmp++; if (push_q.size() !== 1) begin nerr++; $display("FAIL cpl_launch_push got %0d exp 1", push_q.size()); end
    rd(11'h008, d);
    ncmp++; if (d !== 32'h1) begin nerr++; $display("FAIL cpl_launch_status got %h exp 1", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    do_reset();
    wr(11'h010 + 11'd24, 32'h4444_0000); wait_idle(4, "rm_addr");
    wr(11'h000, 32'h8); wait_idle(20, "rm_issue");
    pulse_compl(2'd3);
    fifo_pfull = 1'b1;
    wr(11'h000, 32'h7);
    rd(11'h000, d);
    ncmp++; if (d !== 32'h7) begin nerr++; $display("FAIL rm_pending got %h exp 7", d); end
    push_q.delete(); push_cyc_q.delete();
    rst = 1'b1;
    tick();
    ncmp++; if (wr_busy !== 1'b0) begin nerr++; $display("FAIL rm_busy got %b exp 0", wr_busy); end
    ncmp++; if (push !== 1'b0) begin nerr++; $display("FAIL rm_push got %b exp 0", push); end
    ncmp++; if (din !== 128'h0) begin nerr++; $display("FAIL rm_din got %h exp 0", din); end
    ncmp++; if (irq !== 1'b0) begin nerr++; $display("FAIL rm_irq got %b exp 0", irq); end
    ncmp++; if (rd_data !== 32'h0) begin nerr++; $display("FAIL rm_rd_data got %h exp 0", rd_data); end
    rst = 1'b0; fifo_pfull = 1'b0;
    repeat (10) tick();
    ncmp++; if (push_q.size() !== 0) begin nerr++; $display("FAIL rm_no_push got %0d exp 0", push_q.size()); end
    rd(11'h000, d);
    ncmp++; if (d !== 32'h0) begin nerr++; $display("FAIL rm_cmd_rd got %h exp 0", d); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_launch_rr();
    test_backpressure();
    test_completion();
    test_errors();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
